// File: rtl/gate_table_tester_if.sv
// ---------------------------------------------------------------------------
// gate_table_tester_if
// Bundles the run-control handshake, the gate-block drive/sample lines and
// the result flags of gate_table_tester.
//   start      : run request into the tester
//   s_in[7:0]  : gate-block outputs sampled by the tester
//   e0, e1     : drive to the gate-block inputs
//   busy, done : run-in-progress level and end-of-run pulse
//   pass       : last completed run had no mismatch
//   fail_mask  : per-gate mismatch flags
//   fail_vec   : per-vector mismatch flags
// slave modport  : the tester itself.
// master modport : whatever requests runs and hosts the gate block.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface gate_table_tester_if;
  logic       start;
  logic [7:0] s_in;
  logic       e0;
  logic       e1;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_mask;
  logic [3:0] fail_vec;

  modport slave (
    input  start, s_in,
    output e0, e1, busy, done, pass, fail_mask, fail_vec
  );

  modport master (
    output start, s_in,
    input  e0, e1, busy, done, pass, fail_mask, fail_vec
  );
endinterface

`default_nettype wire

// File: rtl/gate_table_tester.sv
// ---------------------------------------------------------------------------
// gate_table_tester
// Truth-table driver and checker for a two-input logic-gate block.
// Steps {e1,e0} through 00,01,10,11, holds each vector for SETTLE+1 cycles,
// samples the eight gate outputs in the last cycle of each vector and
// compares them against the golden AND/OR/XOR/NAND/NOR/XNOR/NOT/YES values.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : gate_table_tester_if.slave (start, s_in, e0, e1, busy, done,
//            pass, fail_mask, fail_vec)
// Parameters:
//   SETTLE : cycles e0/e1 are held before the sample cycle (0..255)
//   CNT_W  : settle counter width, must hold SETTLE
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module gate_table_tester #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  wire                   clk,
  input  wire                   rst_n,
  gate_table_tester_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // With SETTLE=0 there is no wait phase and every vector is a single
  // sample cycle; the reload value is then never used.
  localparam bit               c_HAS_WAIT = (SETTLE > 0);
  localparam logic [CNT_W-1:0] c_RELOAD   = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;
  localparam state_t           c_AFTER_SET = c_HAS_WAIT ? ST_WAIT : ST_SAMPLE;

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_e0;
  logic             r_e1;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [7:0]       r_fail_mask;
  logic [3:0]       r_fail_vec;

  logic [7:0]       w_expected;
  logic [7:0]       w_diff;

  // Golden outputs as s7..s0 for the vector currently driven.
  always_comb begin
    w_expected = 8'h00;
    case (r_idx)
      2'd0: w_expected = 8'h78;
      2'd1: w_expected = 8'h8E;
      2'd2: w_expected = 8'h4E;
      2'd3: w_expected = 8'hA3;
      default: w_expected = 8'h00;
    endcase
  end

  assign w_diff = bus.s_in ^ w_expected;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_e0        <= 1'b0;
      r_e1        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= 8'h00;
      r_fail_vec  <= 4'h0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_fail_mask <= 8'h00;
            r_fail_vec  <= 4'h0;
            r_pass      <= 1'b0;
            r_idx       <= 2'd0;
            r_e0        <= 1'b0;
            r_e1        <= 1'b0;
            r_busy      <= 1'b1;
            r_cnt       <= c_RELOAD;
            r_state     <= c_AFTER_SET;
          end
        end

        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          r_fail_mask <= r_fail_mask | w_diff;
          if (w_diff != 8'h00) begin
            r_fail_vec[r_idx] <= 1'b1;
          end
          if (r_idx != 2'd3) begin
            r_idx        <= r_idx + 2'd1;
            {r_e1, r_e0} <= r_idx + 2'd1;
            r_cnt        <= c_RELOAD;
            r_state      <= c_AFTER_SET;
          end else begin
            // Outputs are registered, so the DONE-cycle values are loaded
            // here; pass has to fold in the final sample directly.
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= ((r_fail_mask | w_diff) == 8'h00);
            r_e0    <= 1'b0;
            r_e1    <= 1'b0;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.e0        = r_e0;
  assign bus.e1        = r_e1;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.fail_mask = r_fail_mask;
  assign bus.fail_vec  = r_fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_gate_table_tester.sv
`default_nettype none

module tb_gate_table_tester;

  typedef struct packed {
    logic [7:0] mask;
    logic [3:0] vec;
    logic       pass;
  } sb_t;

  localparam logic [7:0] GOLDEN [4] = '{8'h78, 8'h8E, 8'h4E, 8'hA3};

  logic clk;
  logic rst_n;

  // Fault injection per DUT: bits forced to 0, then bits inverted.
  logic [7:0] st0_a, inv_a, st0_b, inv_b;

  int   n_checks;
  int   n_fail;
  sb_t  sb_q[$];

  gate_table_tester_if if_a ();
  gate_table_tester_if if_b ();

  gate_table_tester #(.SETTLE(2), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  gate_table_tester #(.SETTLE(0), .CNT_W(8)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gate_model(input logic e0, input logic e1);
    return {e0, ~e0, ~(e0 ^ e1), ~(e0 | e1), ~(e0 & e1), e0 ^ e1, e0 | e1, e0 & e1};
  endfunction

  assign if_a.s_in = (gate_model(if_a.e0, if_a.e1) & ~st0_a) ^ inv_a;
  assign if_b.s_in = (gate_model(if_b.e0, if_b.e1) & ~st0_b) ^ inv_b;

  function automatic sb_t predict(input logic [7:0] st0, input logic [7:0] inv);
    sb_t        r;
    logic [1:0] k;
    logic [7:0] d;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      k = 2'(i);
      d = ((gate_model(k[0], k[1]) & ~st0) ^ inv) ^ GOLDEN[i];
      r.mask = r.mask | d;
      if (d != 8'h00) r.vec[i] = 1'b1;
    end
    r.pass = (r.mask == 8'h00);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) if_a.start = v;
    else          if_b.start = v;
  endtask

  function automatic logic [1:0] get_e(input int sel);
    return (sel == 0) ? {if_a.e1, if_a.e0} : {if_b.e1, if_b.e0};
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? if_a.busy : if_b.busy;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? if_a.done : if_b.done;
  endfunction
  function automatic logic get_pass(input int sel);
    return (sel == 0) ? if_a.pass : if_b.pass;
  endfunction
  function automatic logic [7:0] get_mask(input int sel);
    return (sel == 0) ? if_a.fail_mask : if_b.fail_mask;
  endfunction
  function automatic logic [3:0] get_vec(input int sel);
    return (sel == 0) ? if_a.fail_vec : if_b.fail_vec;
  endfunction

  // One run: sel 0 -> SETTLE=2 DUT, sel 1 -> SETTLE=0 DUT.
  // restart_at / reset_at: cycle (after the start edge) at which a spurious
  // start pulse / a reset is applied; 0 disables.
  task automatic do_run(input int sel, input logic [7:0] st0, input logic [7:0] inv,
                        input int restart_at, input int reset_at);
    int  s, done_c, limit, ndone, got_c, eseq_err;
    bit  aborted;
    sb_t exp, got;
    s      = (sel == 0) ? 2 : 0;
    done_c = 4 * (s + 1) + 1;
    limit  = done_c + 6;
    ndone = 0; got_c = 0; eseq_err = 0; aborted = 0;
    exp = '0;
    if (sel == 0) begin st0_a = st0; inv_a = inv; end
    else          begin st0_b = st0; inv_b = inv; end
    sb_q.push_back(predict(st0, inv));
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int c = 1; c <= limit; c++) begin
      if (c == 1) begin
        check("start_busy", 32'(get_busy(sel)), 32'd1);
        check("start_clr_mask", 32'(get_mask(sel)), 32'h0);
        check("start_clr_vec", 32'(get_vec(sel)), 32'h0);
        check("start_clr_pass", 32'(get_pass(sel)), 32'd0);
      end
      if (restart_at != 0 && c == restart_at)     set_start(sel, 1'b1);
      if (restart_at != 0 && c == restart_at + 1) set_start(sel, 1'b0);
      if (reset_at != 0 && c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_e", 32'(get_e(sel)), 32'h0);
        check("rst_busy", 32'(get_busy(sel)), 32'd0);
        check("rst_mask", 32'(get_mask(sel)), 32'h0);
        check("rst_vec", 32'(get_vec(sel)), 32'h0);
        check("rst_done", 32'(get_done(sel)), 32'd0);
        aborted = 1;
        void'(sb_q.pop_front());
      end
      if (reset_at != 0 && c == reset_at + 1) rst_n = 1'b1;
      if (!aborted && c <= 4 * (s + 1) && int'(get_e(sel)) != (c - 1) / (s + 1))
        eseq_err++;
      if (get_done(sel)) begin
        ndone++;
        if (ndone == 1) begin
          got_c = c;
          exp = sb_q.pop_front();
          got.mask = get_mask(sel);
          got.vec  = get_vec(sel);
          got.pass = get_pass(sel);
          check("fail_mask", 32'(got.mask), 32'(exp.mask));
          check("fail_vec", 32'(got.vec), 32'(exp.vec));
          check("pass", 32'(got.pass), 32'(exp.pass));
          check("done_e", 32'(get_e(sel)), 32'h0);
          check("done_busy", 32'(get_busy(sel)), 32'd0);
        end
      end
      if (got_c != 0 && c == got_c + 2) begin
        check("hold_pass", 32'(get_pass(sel)), 32'(exp.pass));
        check("hold_mask", 32'(get_mask(sel)), 32'(exp.mask));
      end
      @(negedge clk);
    end
    if (aborted) begin
      check("abort_no_done", 32'(ndone), 32'd0);
    end else begin
      if (ndone == 0) void'(sb_q.pop_front());
      check("done_cycle", 32'(got_c), 32'(done_c));
      check("done_count", 32'(ndone), 32'd1);
      check("e_sequence", 32'(eseq_err), 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    st0_a = 8'h00; inv_a = 8'h00;
    st0_b = 8'h00; inv_b = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(if_a.busy), 32'd0);
    check("reset_done", 32'(if_a.done), 32'd0);
    check("reset_pass", 32'(if_a.pass), 32'd0);
    check("reset_mask", 32'(if_a.fail_mask), 32'h0);
    check("reset_vec", 32'(if_a.fail_vec), 32'h0);
    check("reset_e", 32'({if_a.e1, if_a.e0}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_run(0, 8'h00, 8'h00, 0, 0);   // golden, SETTLE=2
    do_run(0, 8'h04, 8'h00, 0, 0);   // XOR stuck at 0
    do_run(0, 8'h00, 8'h80, 0, 0);   // YES inverted
    do_run(1, 8'h00, 8'h00, 2, 0);   // golden, SETTLE=0, spurious start mid-run
    do_run(0, 8'h00, 8'h80, 0, 7);   // reset during vector-2 wait
    do_run(0, 8'h00, 8'h00, 0, 0);   // full run after the abort
    do_run(0, 8'h00, 8'h01, 0, 0);   // failing run, AND inverted
    do_run(0, 8'h00, 8'h00, 0, 0);   // golden run right after

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
